lcd_port_arbiter: RTL and testbench

LCD_PORT_ARBITER -- requirements
Module: lcd_port_arbiter

---
 rtl/lcd_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_lcd_port_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_port_arbiter.sv
// Shares one LCD write port between a CPU holding register and a keyboard scan-code FIFO.
// A round-robin sequencer emits one-cycle write pulses, each followed by an enforced hold gap.
module lcd_port_arbiter #(
    parameter int KEY_DEPTH   = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_write,
    input  logic [31:0] cpu_data,
    input  logic        ps2_key_pressed,
    input  logic [7:0]  ps2_out,
    input  logic        lcd_busy,
    output logic        lcd_write,
    output logic [31:0] lcd_data,
    output logic        cpu_stall,
    output logic        key_overflow
);
    localparam int PTR_W = (KEY_DEPTH > 1) ? $clog2(KEY_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [3:0]       HOLD_INIT = 4'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(KEY_DEPTH);

    typedef enum logic [1:0] {IDLE, PULSE, HOLD} state_t;

    state_t           state;
    logic             hold_valid;
    logic [31:0]      hold_data;
    logic             key_sync;
    logic             key_prev;
    logic [7:0]       fifo_mem [KEY_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic             last_grant_key;
    logic [3:0]       hold_cnt;

    logic key_rise;
    logic cpu_pending;
    logic key_pending;
    logic can_grant;
    logic grant_cpu;
    logic grant_key;
    logic fifo_full;
    logic push_ok;

    assign key_rise    = key_sync & ~key_prev;
    assign cpu_pending = hold_valid;
    assign key_pending = (fifo_count != '0);
    assign fifo_full   = (fifo_count == FIFO_FULL);
    assign can_grant   = (state == IDLE) && !lcd_busy && (cpu_pending || key_pending);
    // The CPU wins contention only when the keyboard was the previous grantee.
    assign grant_cpu   = can_grant && cpu_pending && (!key_pending || last_grant_key);
    assign grant_key   = can_grant && !grant_cpu;
    // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
    assign push_ok     = key_rise && (!fifo_full || grant_key);

    assign cpu_stall = hold_valid;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (grant_cpu) begin
            hold_valid <= 1'b0;
        end else if (cpu_write && !hold_valid) begin
            hold_valid <= 1'b1;
            hold_data  <= cpu_data;
        end
    end

    // Two registered copies of the key level; the rise is seen one cycle after sampling.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            key_sync <= 1'b0;
            key_prev <= 1'b0;
        end else begin
            key_sync <= ps2_key_pressed;
            key_prev <= key_sync;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= ps2_out;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            key_overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (grant_key) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, grant_key})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (key_rise && !push_ok) begin
                key_overflow <= 1'b1;
            end
        end
    end

    // The hold counter saturates at zero and releases on the edge it would reach zero,
    // giving HOLD_CYCLES hold cycles plus one idle cycle between pulses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            lcd_write      <= 1'b0;
            lcd_data       <= '0;
            hold_cnt       <= '0;
            last_grant_key <= 1'b1;
        end else begin
            lcd_write <= 1'b0;
            case (state)
                IDLE: begin
                    if (can_grant) begin
                        state          <= PULSE;
                        lcd_write      <= 1'b1;
                        last_grant_key <= grant_key;
                        lcd_data       <= grant_cpu ? hold_data : {24'h0, fifo_mem[rd_ptr]};
                    end
                end
                PULSE: begin
                    state    <= HOLD;
                    hold_cnt <= HOLD_INIT;
                end
                HOLD: begin
                    if (hold_cnt != 4'd0) begin
                        hold_cnt <= hold_cnt - 4'd1;
                    end
                    if ((hold_cnt < 4'd2) && !lcd_busy) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_port_arbiter.sv
// Self-checking bench for lcd_port_arbiter: hand-derived vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_lcd_port_arbiter;
    localparam int KEY_DEPTH   = 4;
    localparam int HOLD_CYCLES = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_write = 1'b0;
    logic [31:0] cpu_data = '0;
    logic        ps2_key_pressed = 1'b0;
    logic [7:0]  ps2_out = '0;
    logic        lcd_busy = 1'b0;
    logic        lcd_write;
    logic [31:0] lcd_data;
    logic        cpu_stall;
    logic        key_overflow;

    lcd_port_arbiter #(.KEY_DEPTH(KEY_DEPTH), .HOLD_CYCLES(HOLD_CYCLES)) dut (
        .clock(clock), .reset(reset), .cpu_write(cpu_write), .cpu_data(cpu_data),
        .ps2_key_pressed(ps2_key_pressed), .ps2_out(ps2_out), .lcd_busy(lcd_busy),
        .lcd_write(lcd_write), .lcd_data(lcd_data), .cpu_stall(cpu_stall),
        .key_overflow(key_overflow)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int pulse_cycles[$];
    logic [31:0] pulse_data[$];

    // Reference model: pending CPU word, key queue, and a gap timer counting edges since the last grant.
    bit          m_valid;
    logic [31:0] m_hold;
    logic [31:0] m_queue[$];
    bit          m_s1, m_s2;
    bit          m_released;
    int          m_since;
    bit          m_last_key;
    bit          m_write;
    logic [31:0] m_data;
    bit          m_ovf;

    typedef struct {
        logic        cw;
        logic [31:0] cd;
        logic        key;
        logic [7:0]  ko;
        logic        busy;
        logic        ew;
        logic [31:0] ed;
        logic        es;
        logic        eo;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s @cyc %0d: got %h expected %h", name, cyc, actual, expected);
        end
    endtask

    task automatic modelReset();
        m_valid = 0; m_hold = '0; m_queue.delete();
        m_s1 = 0; m_s2 = 0; m_released = 1; m_since = 0;
        m_last_key = 1; m_write = 0; m_data = '0; m_ovf = 0;
    endtask

    task automatic modelEdge();
        bit cpu_pend, key_pend, rise, pick_cpu;
        cpu_pend = m_valid;
        key_pend = (m_queue.size() > 0);
        rise = m_s1 && !m_s2;
        m_write = 0;
        if (!m_released) begin
            m_since++;
            if (m_since > HOLD_CYCLES && !lcd_busy) m_released = 1;
        end else if (!lcd_busy && (cpu_pend || key_pend)) begin
            pick_cpu = (cpu_pend && key_pend) ? m_last_key : cpu_pend;
            m_released = 0;
            m_since = 0;
            m_write = 1;
            m_last_key = !pick_cpu;
            if (pick_cpu) begin
                m_data = m_hold;
                m_valid = 0;
            end else begin
                m_data = m_queue.pop_front();
            end
        end
        if (cpu_write && !cpu_pend) begin
            m_valid = 1;
            m_hold = cpu_data;
        end
        if (rise) begin
            if (m_queue.size() < KEY_DEPTH) m_queue.push_back({24'h0, ps2_out});
            else m_ovf = 1;
        end
        m_s2 = m_s1;
        m_s1 = ps2_key_pressed;
    endtask

    task automatic applyStimulus(input logic cw, input logic [31:0] cd, input logic key,
                                 input logic [7:0] ko, input logic busy);
        cpu_write = cw; cpu_data = cd; ps2_key_pressed = key; ps2_out = ko; lcd_busy = busy;
        @(posedge clock);
        modelEdge();
        @(negedge clock);
        cyc++;
        if (lcd_write === 1'b1) begin
            pulse_cycles.push_back(cyc);
            pulse_data.push_back(lcd_data);
        end
    endtask

    task automatic checkOutput();
        check("lcd_write", {31'h0, lcd_write}, {31'h0, m_write});
        check("lcd_data", lcd_data, m_data);
        check("cpu_stall", {31'h0, cpu_stall}, {31'h0, m_valid});
        check("key_overflow", {31'h0, key_overflow}, {31'h0, m_ovf});
    endtask

    task automatic clearLog();
        pulse_cycles.delete();
        pulse_data.delete();
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, "_write"}, {31'h0, lcd_write}, 32'h0);
        check({tag, "_data"}, lcd_data, 32'h0);
        check({tag, "_stall"}, {31'h0, cpu_stall}, 32'h0);
        check({tag, "_ovf"}, {31'h0, key_overflow}, 32'h0);
    endtask

    task automatic doReset();
        cpu_write = 0; cpu_data = '0; ps2_key_pressed = 0; ps2_out = '0; lcd_busy = 0;
        reset = 1'b0;
        #1;
        checkResetOutputs("reset");
        modelReset();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        clearLog();
    endtask

    initial begin
        bit key_lvl;
        bit busy_lvl;
        bit seen;

        vecs[0]  = '{1'b1, 32'hDEADBEEF, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0};
        vecs[1]  = '{1'b0, 32'h0,        1'b0, 8'h00, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 32'h0,        1'b0, 8'h00, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 32'h0,        1'b0, 8'h00, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 32'h0,        1'b0, 8'h00, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 32'h0,        1'b1, 8'h1C, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 32'h0,        1'b1, 8'h1C, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 32'h0,        1'b1, 8'h1C, 1'b0, 1'b1, 32'h0000001C, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 32'h1,        1'b1, 8'h1C, 1'b0, 1'b0, 32'h0000001C, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 32'h2,        1'b1, 8'h1C, 1'b0, 1'b0, 32'h0000001C, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 32'h0,        1'b0, 8'h00, 1'b0, 1'b0, 32'h0000001C, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 32'h0,        1'b0, 8'h00, 1'b0, 1'b1, 32'h00000001, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 32'h0,        1'b0, 8'h00, 1'b0, 1'b0, 32'h00000001, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 32'h0,        1'b0, 8'h00, 1'b0, 1'b0, 32'h00000001, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 32'h0,        1'b0, 8'h00, 1'b0, 1'b0, 32'h00000001, 1'b0, 1'b0};

        @(negedge clock);
        doReset();

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].cw, vecs[i].cd, vecs[i].key, vecs[i].ko, vecs[i].busy);
            check($sformatf("tbl%0d_write", i), {31'h0, lcd_write}, {31'h0, vecs[i].ew});
            check($sformatf("tbl%0d_data", i), lcd_data, vecs[i].ed);
            check($sformatf("tbl%0d_stall", i), {31'h0, cpu_stall}, {31'h0, vecs[i].es});
            check($sformatf("tbl%0d_ovf", i), {31'h0, key_overflow}, {31'h0, vecs[i].eo});
        end

        // CPU write and key press in the same cycle: CPU first, key second, fixed spacing.
        doReset();
        applyStimulus(1'b1, 32'h1, 1'b1, 8'h1C, 1'b0);
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 8'h1C, 1'b0);
            checkOutput();
        end
        check("contend_count", pulse_data.size(), 2);
        if (pulse_data.size() == 2) begin
            check("contend_first", pulse_data[0], 32'h1);
            check("contend_second", pulse_data[1], 32'h1C);
            check("contend_spacing", pulse_cycles[1] - pulse_cycles[0], HOLD_CYCLES + 2);
        end

        // Five key presses while the LCD is busy: fourth fills the FIFO, fifth is dropped.
        doReset();
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 8'h10 + 8'(k), 1'b1);
            checkOutput();
            applyStimulus(1'b0, 32'h0, 1'b0, 8'h10 + 8'(k), 1'b1);
            checkOutput();
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 8'h00, 1'b1);
        checkOutput();
        check("ovf_flag", {31'h0, key_overflow}, 32'h1);
        check("ovf_no_pulse_busy", pulse_data.size(), 0);
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 8'h00, 1'b0);
            checkOutput();
        end
        check("ovf_count", pulse_data.size(), 4);
        for (int k = 0; k < 4 && k < pulse_data.size(); k++) begin
            check($sformatf("ovf_data%0d", k), pulse_data[k], 32'h10 + k);
        end
        check("ovf_sticky", {31'h0, key_overflow}, 32'h1);

        // Backpressure during HOLD keeps the sequencer parked until lcd_busy falls.
        doReset();
        applyStimulus(1'b1, 32'hA5A5_0001, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 32'hA5A5_0002, 1'b0, 8'h00, 1'b0);
        checkOutput();
        clearLog();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 8'h00, 1'b1);
            checkOutput();
        end
        check("bp_no_pulse", pulse_data.size(), 0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 8'h00, 1'b0);
            checkOutput();
        end
        check("bp_pulse_count", pulse_data.size(), 1);
        if (pulse_data.size() == 1) begin
            check("bp_pulse_data", pulse_data[0], 32'hA5A5_0002);
            check("bp_pulse_delay", pulse_cycles[0] - cyc + 8, 2);
        end

        // Reset asserted while the pulse is on the port; a key byte is also queued.
        doReset();
        applyStimulus(1'b1, 32'h00C0FFEE, 1'b1, 8'h55, 1'b0);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 8'h55, 1'b0);
            if (lcd_write === 1'b1) seen = 1;
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL midreset_pulse_timeout: got no pulse expected pulse within 10 cycles");
        end
        ps2_key_pressed = 1'b0;
        reset = 1'b0;
        #1;
        checkResetOutputs("midreset");
        modelReset();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        clearLog();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 8'h00, 1'b0);
            checkOutput();
        end
        check("midreset_no_stale", pulse_data.size(), 0);

        // Randomized traffic against the reference model.
        doReset();
        key_lvl = 0;
        busy_lvl = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) key_lvl = !key_lvl;
            if ($urandom_range(0, 5) == 0) busy_lvl = !busy_lvl;
            applyStimulus($urandom_range(0, 3) == 0, $urandom, key_lvl, 8'($urandom), busy_lvl);
            checkOutput();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
